// File: rtl/mio_cli_st_pkg.sv
// Shared types and widths for the bob->alice packet relay.
// Holds the output FSM state encoding, the header/counter widths and the saturating increment.
package mio_cli_st_pkg;

  localparam int HDR_W     = 8;
  localparam int PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } relay_state_t;

  function automatic logic [PKT_CNT_W-1:0] sat_inc(input logic [PKT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mio_cli_st_sync_fifo.sv
// Single-clock FIFO with occupancy output and a combinational head read.
// A push while full or a pop while empty is ignored.
module mio_cli_st_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: it is only read while level says it holds valid data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mio_cli_st_pkt_relay.sv
// Relays bob packets to alice, prefixing each with an 8-bit sequence-number header.
// Bytes are buffered in a FIFO; the header goes out as soon as the first byte is stored.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no packet in progress, waiting for a buffered byte
//   HDR     | presenting sequence-number header to alice
//   BODY    | forwarding buffered bytes until the byte tagged last is taken
module mio_cli_st_pkt_relay
  import mio_cli_st_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bob_valid,
  output logic                   bob_ready,
  input  logic [DATA_W-1:0]      bob_data,
  input  logic                   bob_last,
  output logic                   alice_valid,
  input  logic                   alice_ready,
  output logic [DATA_W-1:0]      alice_data,
  output logic                   alice_last,
  output logic [PKT_CNT_W-1:0]   pkt_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  relay_state_t     state_q;
  relay_state_t     state_d;
  logic [HDR_W-1:0] seq_q;
  logic             accept_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [DATA_W:0]  fifo_head;
  logic             pkt_done;

  // Holds bob_ready low for the first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) accept_en <= 1'b0;
    else       accept_en <= 1'b1;
  end

  assign bob_ready = accept_en && !fifo_full;
  assign fifo_push = bob_valid && bob_ready;

  mio_cli_st_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({bob_last, bob_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    alice_valid = 1'b0;
    alice_data  = '0;
    alice_last  = 1'b0;
    fifo_pop    = 1'b0;
    pkt_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_HDR;
      end
      ST_HDR: begin
        alice_valid = 1'b1;
        alice_data  = DATA_W'(seq_q);
        if (alice_ready) state_d = ST_BODY;
      end
      ST_BODY: begin
        // Outputs follow the FIFO head, which cannot move while alice stalls.
        if (!fifo_empty) begin
          alice_valid = 1'b1;
          alice_data  = fifo_head[DATA_W-1:0];
          alice_last  = fifo_head[DATA_W];
          if (alice_ready) begin
            fifo_pop = 1'b1;
            if (fifo_head[DATA_W]) begin
              pkt_done = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q     <= '0;
      pkt_count <= '0;
    end else if (pkt_done) begin
      seq_q     <= seq_q + 1'b1;
      pkt_count <= sat_inc(pkt_count);
    end
  end

endmodule

// File: tb/tb_mio_cli_st_pkt_relay.sv
// Randomized bench for the bob->alice relay against a stream-level packet model.
// The model turns every accepted bob byte into expected alice items (header + payload).
module tb_mio_cli_st_pkt_relay;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bob_valid = 1'b0;
  logic        bob_ready;
  logic [7:0]  bob_data = 8'h00;
  logic        bob_last = 1'b0;
  logic        alice_valid;
  logic        alice_ready = 1'b0;
  logic [7:0]  alice_data;
  logic        alice_last;
  logic [15:0] pkt_count;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  // Model state: expected items are {is_hdr, last, data}; source and observed items are {last, data}.
  logic [9:0] exp_q[$];
  logic [8:0] src_q[$];
  logic [8:0] obs_q[$];
  int         m_seq, m_level, m_pkts, n_wr, n_pay, n_out, n_hdr, tog;
  bit         m_in_pkt, m_rdy_ok, prev_stall, last_wr, last_rd;
  logic [7:0] prev_data, last_hdr;
  logic       prev_last;

  always #5 clk = ~clk;

  mio_cli_st_pkt_relay #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bob_valid   (bob_valid),
    .bob_ready   (bob_ready),
    .bob_data    (bob_data),
    .bob_last    (bob_last),
    .alice_valid (alice_valid),
    .alice_ready (alice_ready),
    .alice_data  (alice_data),
    .alice_last  (alice_last),
    .pkt_count   (pkt_count),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    src_q.delete();
    m_seq = 0; m_level = 0; m_pkts = 0;
    m_in_pkt = 0; m_rdy_ok = 0; prev_stall = 0; tog = 0;
  endtask

  // One cycle, entered at a falling edge: drive, check, update model, advance to next falling edge.
  task automatic step(input int vpct, input int rmode);
    logic [9:0] e;
    if (src_q.size() != 0 && $urandom_range(99) < vpct) begin
      bob_valid = 1'b1;
      {bob_last, bob_data} = src_q[0];
    end else begin
      bob_valid = 1'b0;
      bob_data  = 8'($urandom);
      bob_last  = 1'($urandom);
    end
    case (rmode)
      0:       alice_ready = 1'b1;
      1:       begin alice_ready = tog[0]; tog++; end
      2:       alice_ready = 1'($urandom);
      default: alice_ready = 1'b0;
    endcase
    #1;
    chk("fifo_level", fifo_level, m_level);
    chk("pkt_count", pkt_count, m_pkts);
    chk("bob_ready", bob_ready, m_rdy_ok && (m_level < DEPTH));
    if (prev_stall) begin
      chk("stall_valid", alice_valid, 1);
      chk("stall_data", alice_data, prev_data);
      chk("stall_last", alice_last, prev_last);
    end
    last_wr = bob_valid && bob_ready;
    last_rd = alice_valid && alice_ready;
    if (last_wr) begin
      if (!m_in_pkt) begin
        exp_q.push_back({1'b1, 1'b0, 8'(m_seq)});
        m_in_pkt = 1;
      end
      exp_q.push_back({1'b0, bob_last, bob_data});
      if (bob_last) begin
        m_in_pkt = 0;
        m_seq = (m_seq + 1) % 256;
      end
      void'(src_q.pop_front());
      m_level++;
      n_wr++;
    end
    if (last_rd) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("alice_data", alice_data, e[7:0]);
        chk("alice_last", alice_last, e[8]);
        obs_q.push_back({alice_last, alice_data});
        n_out++;
        if (e[9]) begin
          last_hdr = alice_data;
          n_hdr++;
        end else begin
          m_level--;
          n_pay++;
          if (e[8] && m_pkts < 65535) m_pkts++;
        end
      end
    end
    prev_stall = alice_valid && !alice_ready;
    prev_data  = alice_data;
    prev_last  = alice_last;
    m_rdy_ok   = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bob_valid = 1'b0;
    alice_ready = 1'b0;
    #1;
    chk("rst_alice_valid", alice_valid, 0);
    chk("rst_alice_data", alice_data, 0);
    chk("rst_alice_last", alice_last, 0);
    chk("rst_bob_ready", bob_ready, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input int vpct, input int rmode);
    for (int i = 0; i < max_cyc && !(src_q.size() == 0 && exp_q.size() == 0); i++)
      step(vpct, rmode);
    chk("drain_done", (src_q.size() == 0) && (exp_q.size() == 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    clear_model();
    @(negedge clk);
    apply_reset();

    // Three-byte packet with alice always ready.
    obs_q.delete();
    src_q.push_back(9'h011); src_q.push_back(9'h022); src_q.push_back(9'h133);
    drain(100, 100, 0);
    chk("t1_count", obs_q.size(), 4);
    chk("t1_hdr", obs_q[0], 9'h000);
    chk("t1_b0", obs_q[1], 9'h011);
    chk("t1_b1", obs_q[2], 9'h022);
    chk("t1_b2", obs_q[3], 9'h133);
    chk("t1_pkt_count", pkt_count, 1);

    // Fill to full with alice stalled, then drain.
    n_wr = 0;
    for (int i = 0; i < 20; i++) src_q.push_back({1'b0, 8'(8'hA0 + i)});
    for (int i = 0; i < 30; i++) step(100, 3);
    chk("full_writes", n_wr, 16);
    chk("full_level", fifo_level, 16);
    chk("full_bob_ready", bob_ready, 0);
    src_q.push_back(9'h15A);
    drain(200, 100, 0);
    chk("full_pkt_count", pkt_count, 2);

    // Simultaneous push and pop at level 5.
    apply_reset();
    step(0, 3);
    n_wr = 0;
    for (int i = 0; i < 6; i++) src_q.push_back({1'b0, 8'(8'h50 + i)});
    for (int i = 0; i < 20 && n_wr < 5; i++) step(100, 3);
    chk("pre_level", fifo_level, 5);
    step(0, 0);
    chk("body_level", fifo_level, 5);
    step(100, 0);
    chk("same_cycle_hs", {last_wr, last_rd}, 2'b11);
    chk("same_cycle_level", fifo_level, 5);
    src_q.push_back(9'h1EE);
    drain(100, 100, 0);

    // 257 single-byte packets: header sequence wraps.
    apply_reset();
    n_hdr = 0;
    for (int i = 0; i < 257; i++) src_q.push_back({1'b1, 8'($urandom)});
    drain(6000, 80, 2);
    chk("wrap_hdrs", n_hdr, 257);
    chk("wrap_last_hdr", last_hdr, 8'h00);
    chk("wrap_pkt_count", pkt_count, 257);

    // Eight-byte packet with alice_ready toggling every cycle.
    n_out = 0;
    for (int i = 0; i < 8; i++) src_q.push_back({(i == 7), 8'($urandom)});
    drain(200, 100, 1);
    chk("toggle_items", n_out, 9);

    // Reset after two of five payload bytes delivered.
    n_pay = 0;
    for (int i = 0; i < 5; i++) src_q.push_back({(i == 4), 8'(8'hC0 + i)});
    for (int i = 0; i < 50 && n_pay < 2; i++) step(100, 0);
    chk("mid_delivered", n_pay, 2);
    apply_reset();
    step(0, 3);
    obs_q.delete();
    src_q.push_back(9'h17E);
    drain(100, 100, 0);
    chk("post_rst_hdr", obs_q[0], 9'h000);
    chk("post_rst_byte", obs_q[1], 9'h17E);
    chk("post_rst_count", pkt_count, 1);

    // Random packet traffic with random back-pressure.
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) src_q.push_back({(i == len - 1), 8'($urandom)});
    end
    drain(4000, 60, 2);
    chk("rand_pkt_count", pkt_count, 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
